conv_layer_scheduler: RTL and testbench

Layer-level sequencer that walks a full 1x1 convolution layer, one output pixel and one 4-filter group at a time. For each (pixel, filter group) it issues a start pulse with IFM and weight base addresses to the pixel-level PE controller, waits for completion, then hands the resulting OFM word to the output write-back port. It sits between the top-level layer configuration registers and the per-pixel conv controller.

---
 rtl/conv_layer_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_scheduler.sv
// Layer-level sequencer for a 1x1 convolution: walks every (pixel, filter group),
// launches the pixel controller for each job and hands its OFM word to write-back.
module conv_layer_scheduler #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned PE_NUM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_channel,
    input  logic [DIM_W-1:0]  cfg_num_filter,
    input  logic [ADDR_W-1:0] cfg_ifm_base,
    input  logic [ADDR_W-1:0] cfg_wgt_base,
    input  logic [ADDR_W-1:0] cfg_ofm_base,
    input  logic              abort,
    output logic              pix_start,
    output logic [ADDR_W-1:0] pix_ifm_addr,
    output logic [ADDR_W-1:0] pix_wgt_addr,
    input  logic              pix_done,
    output logic              ofm_wr_valid,
    input  logic              ofm_wr_ready,
    output logic [ADDR_W-1:0] ofm_wr_addr,
    output logic              busy,
    output logic              layer_done,
    output logic              cfg_err
);

    localparam logic [DIM_W-1:0] PE_D = DIM_W'(PE_NUM);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t             state;
    logic [DIM_W-1:0]   h_q, w_q, c_q, f_q;
    logic [ADDR_W-1:0]  ifm_base_q, wgt_base_q, ofm_base_q;
    logic [DIM_W-1:0]   col_q, row_q;
    logic [DIM_W-1:0]   gf_q;          // first filter index of current group (g*PE_NUM)
    logic [ADDR_W-1:0]  wgt_step;
    logic               cfg_legal;
    logic               last_grp, last_col, last_row;

    assign cfg_legal = (cfg_height != '0) && (cfg_width != '0) &&
                       (cfg_channel != '0) && (cfg_num_filter != '0) &&
                       ((cfg_channel % PE_D) == '0) && ((cfg_num_filter % PE_D) == '0);

    // Weight stride between groups is PE_NUM*C, formed as a chain of adds
    always_comb begin
        wgt_step = '0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            wgt_step = wgt_step + ADDR_W'(c_q);
        end
    end

    assign last_grp = (gf_q == (f_q - PE_D));
    assign last_col = (col_q == (w_q - DIM_W'(1)));
    assign last_row = (row_q == (h_q - DIM_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            h_q          <= '0;
            w_q          <= '0;
            c_q          <= '0;
            f_q          <= '0;
            ifm_base_q   <= '0;
            wgt_base_q   <= '0;
            ofm_base_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            gf_q         <= '0;
            pix_ifm_addr <= '0;
            pix_wgt_addr <= '0;
            ofm_wr_addr  <= '0;
            pix_start    <= 1'b0;
            ofm_wr_valid <= 1'b0;
            layer_done   <= 1'b0;
            cfg_err      <= 1'b0;
            busy         <= 1'b0;
            cfg_ready    <= 1'b1;
        end else begin
            pix_start    <= 1'b0;
            ofm_wr_valid <= 1'b0;
            layer_done   <= 1'b0;
            cfg_err      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        if (cfg_legal) begin
                            h_q        <= cfg_height;
                            w_q        <= cfg_width;
                            c_q        <= cfg_channel;
                            f_q        <= cfg_num_filter;
                            ifm_base_q <= cfg_ifm_base;
                            wgt_base_q <= cfg_wgt_base;
                            ofm_base_q <= cfg_ofm_base;
                            busy       <= 1'b1;
                            cfg_ready  <= 1'b0;
                            state      <= S_LOAD;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    pix_ifm_addr <= ifm_base_q;
                    pix_wgt_addr <= wgt_base_q;
                    ofm_wr_addr  <= ofm_base_q;
                    col_q        <= '0;
                    row_q        <= '0;
                    gf_q         <= '0;
                    pix_start    <= 1'b1;
                    state        <= S_ISSUE;
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (pix_done) begin
                        ofm_wr_valid <= 1'b1;
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (ofm_wr_ready) begin
                        state <= S_NEXT;
                    end else begin
                        ofm_wr_valid <= 1'b1;
                    end
                end
                S_NEXT: begin
                    // OFM words for consecutive groups and pixels are contiguous
                    ofm_wr_addr <= ofm_wr_addr + ADDR_W'(PE_NUM);
                    if (!last_grp) begin
                        gf_q         <= gf_q + PE_D;
                        pix_wgt_addr <= pix_wgt_addr + wgt_step;
                    end else begin
                        gf_q         <= '0;
                        pix_wgt_addr <= wgt_base_q;
                        pix_ifm_addr <= pix_ifm_addr + ADDR_W'(c_q);
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                    end
                    if (last_grp && last_col && last_row) begin
                        layer_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        pix_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase

            // Abort wins over every handshake sampled this cycle
            if (abort && (state != S_IDLE)) begin
                pix_start    <= 1'b0;
                ofm_wr_valid <= 1'b0;
                layer_done   <= 1'b0;
                busy         <= 1'b0;
                cfg_ready    <= 1'b1;
                state        <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: logs starts/writes at the falling edge
// and compares them with hand-computed address sequences.
module tb_conv_layer_scheduler;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DIM_W  = 8;
    localparam int unsigned PE_NUM = 4;

    logic              clk;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIM_W-1:0]  cfg_height, cfg_width, cfg_channel, cfg_num_filter;
    logic [ADDR_W-1:0] cfg_ifm_base, cfg_wgt_base, cfg_ofm_base;
    logic              abort;
    logic              pix_start;
    logic [ADDR_W-1:0] pix_ifm_addr, pix_wgt_addr;
    logic              pix_done;
    logic              ofm_wr_valid;
    logic              ofm_wr_ready;
    logic [ADDR_W-1:0] ofm_wr_addr;
    logic              busy;
    logic              layer_done;
    logic              cfg_err;

    conv_layer_scheduler #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .PE_NUM(PE_NUM)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_height(cfg_height), .cfg_width(cfg_width),
        .cfg_channel(cfg_channel), .cfg_num_filter(cfg_num_filter),
        .cfg_ifm_base(cfg_ifm_base), .cfg_wgt_base(cfg_wgt_base), .cfg_ofm_base(cfg_ofm_base),
        .abort(abort),
        .pix_start(pix_start), .pix_ifm_addr(pix_ifm_addr), .pix_wgt_addr(pix_wgt_addr),
        .pix_done(pix_done),
        .ofm_wr_valid(ofm_wr_valid), .ofm_wr_ready(ofm_wr_ready), .ofm_wr_addr(ofm_wr_addr),
        .busy(busy), .layer_done(layer_done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q_ifm[$];
    logic [31:0] q_wgt[$];
    logic [31:0] q_ofm[$];
    int done_cnt;
    int err_cnt;
    int n_checks;
    int n_errors;

    // Event log, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_start) begin
                q_ifm.push_back(pix_ifm_addr);
                q_wgt.push_back(pix_wgt_addr);
            end
            if (ofm_wr_valid && ofm_wr_ready) q_ofm.push_back(ofm_wr_addr);
            if (layer_done) done_cnt++;
            if (cfg_err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_ifm.delete();
        q_wgt.delete();
        q_ofm.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Returns #1 after the edge that samples the configuration
    task automatic send_cfg(input logic [7:0] h, input logic [7:0] w, input logic [7:0] c,
                            input logic [7:0] f, input logic [31:0] ib, input logic [31:0] wb,
                            input logic [31:0] ob);
        cfg_height     = h;
        cfg_width      = w;
        cfg_channel    = c;
        cfg_num_filter = f;
        cfg_ifm_base   = ib;
        cfg_wgt_base   = wb;
        cfg_ofm_base   = ob;
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            cycles++;
            if (layer_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pix_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ofm_wr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        bit  ok;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_height = '0; cfg_width = '0; cfg_channel = '0; cfg_num_filter = '0;
        cfg_ifm_base = '0; cfg_wgt_base = '0; cfg_ofm_base = '0;
        abort = 1'b0;
        pix_done = 1'b0;
        ofm_wr_ready = 1'b0;
        clear_log();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_start", 32'(pix_start), 0);
        check("rst_wr_valid", 32'(ofm_wr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ifm_addr", pix_ifm_addr, 0);
        check("rst_wgt_addr", pix_wgt_addr, 0);
        check("rst_ofm_addr", ofm_wr_addr, 0);
        reset = 1'b0;
        tick();
        check("rst_cfg_ready", 32'(cfg_ready), 1);

        // Minimal layer: handshake edge, then LOAD/ISSUE/WAIT/WRITE/NEXT -> DONE after 5 more edges
        clear_log();
        pix_done = 1'b1;
        ofm_wr_ready = 1'b1;
        send_cfg(8'd1, 8'd1, 8'd4, 8'd4, 32'h100, 32'h200, 32'h300);
        check("min_busy", 32'(busy), 1);
        check("min_cfg_ready", 32'(cfg_ready), 0);
        wait_done(20, cyc, ok);
        check("min_done_seen", 32'(ok), 1);
        check("min_done_latency", 32'(cyc), 5);
        tick();
        check("min_idle_busy", 32'(busy), 0);
        check("min_n_starts", 32'(q_ifm.size()), 1);
        check("min_ifm", pick(q_ifm, 0), 32'h100);
        check("min_wgt", pick(q_wgt, 0), 32'h200);
        check("min_n_writes", 32'(q_ofm.size()), 1);
        check("min_ofm", pick(q_ofm, 0), 32'h300);
        check("min_n_done", 32'(done_cnt), 1);

        // 2x2 layer, C=8, F=8: two groups per pixel
        clear_log();
        send_cfg(8'd2, 8'd2, 8'd8, 8'd8, 32'h0, 32'h0, 32'h0);
        wait_done(100, cyc, ok);
        check("l2_done_seen", 32'(ok), 1);
        repeat (4) tick();
        check("l2_n_starts", 32'(q_ifm.size()), 8);
        check("l2_n_writes", 32'(q_ofm.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("l2_ifm[%0d]", i), pick(q_ifm, i), 32'((i / 2) * 8));
            check($sformatf("l2_wgt[%0d]", i), pick(q_wgt, i), 32'((i % 2) * 32));
            check($sformatf("l2_ofm[%0d]", i), pick(q_ofm, i), 32'(i * 4));
        end
        check("l2_n_done", 32'(done_cnt), 1);

        // Backpressure on the first write of a two-pixel layer
        clear_log();
        ofm_wr_ready = 1'b0;
        send_cfg(8'd1, 8'd2, 8'd4, 8'd4, 32'h100, 32'h200, 32'h300);
        wait_wvalid(ok);
        check("bp_valid_seen", 32'(ok), 1);
        check("bp_addr0", ofm_wr_addr, 32'h300);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_valid_hold[%0d]", i), 32'(ofm_wr_valid), 1);
            check($sformatf("bp_addr_hold[%0d]", i), ofm_wr_addr, 32'h300);
            check($sformatf("bp_ifm_hold[%0d]", i), pix_ifm_addr, 32'h100);
            check($sformatf("bp_starts[%0d]", i), 32'(q_ifm.size()), 1);
        end
        ofm_wr_ready = 1'b1;
        wait_done(50, cyc, ok);
        check("bp_done_seen", 32'(ok), 1);
        tick();
        check("bp_n_starts", 32'(q_ifm.size()), 2);
        check("bp_ifm1", pick(q_ifm, 1), 32'h104);
        check("bp_wgt1", pick(q_wgt, 1), 32'h200);
        check("bp_ofm0", pick(q_ofm, 0), 32'h300);
        check("bp_ofm1", pick(q_ofm, 1), 32'h304);

        // Illegal configurations: C not a multiple of 4, then F=0
        clear_log();
        send_cfg(8'd1, 8'd1, 8'd6, 8'd4, 32'h0, 32'h0, 32'h0);
        check("ill_c_err", 32'(cfg_err), 1);
        check("ill_c_busy", 32'(busy), 0);
        tick();
        check("ill_err_pulse", 32'(cfg_err), 0);
        send_cfg(8'd1, 8'd1, 8'd4, 8'd0, 32'h0, 32'h0, 32'h0);
        check("ill_f_err", 32'(cfg_err), 1);
        check("ill_f_busy", 32'(busy), 0);
        repeat (4) tick();
        check("ill_n_starts", 32'(q_ifm.size()), 0);
        check("ill_n_err", 32'(err_cnt), 2);
        check("ill_cfg_ready", 32'(cfg_ready), 1);

        // Abort during the third job's WAIT, with pix_done in the same cycle
        clear_log();
        pix_done = 1'b0;
        send_cfg(8'd2, 8'd2, 8'd8, 8'd8, 32'h0, 32'h0, 32'h0);
        for (int j = 0; j < 2; j++) begin
            wait_start(ok);
            check($sformatf("ab_start[%0d]", j), 32'(ok), 1);
            pix_done = 1'b1;
            tick();
            tick();
            pix_done = 1'b0;
        end
        wait_start(ok);
        check("ab_start[2]", 32'(ok), 1);
        tick();
        abort = 1'b1;
        pix_done = 1'b1;
        tick();
        abort = 1'b0;
        pix_done = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_cfg_ready", 32'(cfg_ready), 1);
        check("ab_wr_valid", 32'(ofm_wr_valid), 0);
        repeat (5) tick();
        check("ab_n_writes", 32'(q_ofm.size()), 2);
        check("ab_n_starts", 32'(q_ifm.size()), 3);
        check("ab_n_done", 32'(done_cnt), 0);
        clear_log();
        pix_done = 1'b1;
        send_cfg(8'd1, 8'd1, 8'd4, 8'd4, 32'h40, 32'h80, 32'hC0);
        wait_done(20, cyc, ok);
        check("ab_re_done_seen", 32'(ok), 1);
        tick();
        check("ab_re_ifm", pick(q_ifm, 0), 32'h40);
        check("ab_re_wgt", pick(q_wgt, 0), 32'h80);
        check("ab_re_ofm", pick(q_ofm, 0), 32'hC0);

        // IFM address wraps modulo 2^32
        clear_log();
        send_cfg(8'd1, 8'd4, 8'd4, 8'd4, 32'hFFFF_FFF8, 32'h0, 32'h0);
        wait_done(50, cyc, ok);
        check("wr_done_seen", 32'(ok), 1);
        tick();
        check("wr_ifm0", pick(q_ifm, 0), 32'hFFFF_FFF8);
        check("wr_ifm1", pick(q_ifm, 1), 32'hFFFF_FFFC);
        check("wr_ifm2", pick(q_ifm, 2), 32'h0000_0000);
        check("wr_ifm3", pick(q_ifm, 3), 32'h0000_0004);

        // Asynchronous reset while a write is pending
        clear_log();
        ofm_wr_ready = 1'b0;
        send_cfg(8'd1, 8'd1, 8'd4, 8'd4, 32'h100, 32'h200, 32'h300);
        wait_wvalid(ok);
        check("ar_valid_seen", 32'(ok), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_wr_valid", 32'(ofm_wr_valid), 0);
        check("ar_ofm_addr", ofm_wr_addr, 0);
        check("ar_ifm_addr", pix_ifm_addr, 0);
        check("ar_wgt_addr", pix_wgt_addr, 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_pix_start", 32'(pix_start), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ofm_wr_ready = 1'b1;
        tick();
        check("ar_cfg_ready", 32'(cfg_ready), 1);
        check("ar_idle_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
